// File: rtl/regfile_wr_arbiter.sv
// Register-file write port shared by two requesters: sweeps INIT_DATA into all 32
// registers after reset or init_req, then arbitrates writes round-robin.
module regfile_wr_arbiter #(
   parameter logic [31:0] INIT_DATA = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init_req,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [4:0]       req0_reg,
   input  logic [4:0]       req1_reg,
   input  logic [31:0]      req0_data,
   input  logic [31:0]      req1_data,
   output logic [4:0]       WriteReg,
   output logic [31:0]      WriteData,
   output logic             RegWrite,
   output logic             init_done,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [4:0]       sweep_q, sweep_d;
   logic             last1_q, last1_d;   // 1: requester 1 won the last transfer
   logic [4:0]       wreg_q, wreg_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             rw_q, rw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant0_s, grant1_s, accept_en_s;

   assign init_done    = state_q[0];
   assign WriteReg     = wreg_q;
   assign WriteData    = wdata_q;
   assign RegWrite     = rw_q;
   assign conflict_cnt = cnt_q;

   // Grant selection; init_req suppresses acceptance in the cycle it arrives.
   always_comb begin
      accept_en_s = (state_q == ST_RUN) & ~init_req;
      grant0_s    = req0_valid & (~req1_valid | last1_q);
      grant1_s    = req1_valid & (~req0_valid | ~last1_q);
      req0_ready  = accept_en_s & grant0_s;
      req1_ready  = accept_en_s & grant1_s;
   end

   // Next-state and write-port computation.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      last1_d = last1_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      rw_d    = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            rw_d    = 1'b1;
            wreg_d  = sweep_q;
            wdata_d = INIT_DATA;
            sweep_d = sweep_q + 5'd1;
            if (sweep_q == 5'd31) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_RUN: begin
            if (req0_valid && req1_valid && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
            if (init_req) begin
               state_d = ST_INIT;
               sweep_d = 5'd0;
            end else if (req0_ready) begin
               last1_d = 1'b0;
               // r0 is read-only after init: accept but drop the write
               if (req0_reg != 5'd0) begin
                  rw_d    = 1'b1;
                  wreg_d  = req0_reg;
                  wdata_d = req0_data;
               end else begin
                  rw_d    = 1'b0;
               end
            end else if (req1_ready) begin
               last1_d = 1'b1;
               if (req1_reg != 5'd0) begin
                  rw_d    = 1'b1;
                  wreg_d  = req1_reg;
                  wdata_d = req1_data;
               end else begin
                  rw_d    = 1'b0;
               end
            end else begin
               rw_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT;
            sweep_d = 5'd0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         sweep_q <= 5'd0;
         last1_q <= 1'b1;
         wreg_q  <= 5'd0;
         wdata_q <= 32'h0000_0000;
         rw_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         last1_q <= last1_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table for RUN-mode arbitration
// plus hand sequences for reset, init sweep, init_req and saturation.
module tb_regfile_wr_arbiter;

   localparam logic [31:0] INIT_D = 32'h1234_5678;

   logic        clk;
   logic        reset;
   logic        init_req;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_reg, req1_reg;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        init_done;
   logic [2:0]  conflict_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_wr_arbiter #(.INIT_DATA(INIT_D), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .init_req(init_req),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_reg(req0_reg), .req1_reg(req1_reg),
      .req0_data(req0_data), .req1_data(req1_data),
      .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
      .init_done(init_done), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v0;
      logic [4:0]  r0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  r1;
      logic [31:0] d1;
      logic        rdy0;
      logic        rdy1;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // Idle, single-requester, r0 discard, 4-cycle contention on r3, mixed
      vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd31, INIT_D,        3'd0};
      vecs[1]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h1111_1111, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0};
      vecs[4]  = '{1'b1, 5'd3,  32'hA000_0000, 1'b1, 5'd3,  32'hB000_0000, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA000_0000, 3'd1};
      vecs[5]  = '{1'b1, 5'd3,  32'hA000_0001, 1'b1, 5'd3,  32'hB000_0001, 1'b0, 1'b1, 1'b1, 5'd3,  32'hB000_0001, 3'd2};
      vecs[6]  = '{1'b1, 5'd3,  32'hA000_0002, 1'b1, 5'd3,  32'hB000_0002, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA000_0002, 3'd3};
      vecs[7]  = '{1'b1, 5'd3,  32'hA000_0003, 1'b1, 5'd3,  32'hB000_0003, 1'b0, 1'b1, 1'b1, 5'd3,  32'hB000_0003, 3'd4};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd3,  32'hB000_0003, 3'd4};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hC7C7_C7C7, 1'b0, 1'b1, 1'b1, 5'd7,  32'hC7C7_C7C7, 3'd4};
      vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8,  32'hC8C8_C8C8, 1'b0, 1'b1, 1'b1, 5'd8,  32'hC8C8_C8C8, 3'd4};
      vecs[11] = '{1'b1, 5'd9,  32'hD9D9_D9D9, 1'b1, 5'd9,  32'hE9E9_E9E9, 1'b1, 1'b0, 1'b1, 5'd9,  32'hD9D9_D9D9, 3'd5};
      vecs[12] = '{1'b1, 5'd10, 32'h0A0A_0A0A, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd10, 32'h0A0A_0A0A, 3'd5};

      reset = 1'b0; init_req = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_reg = 5'd0; req1_reg = 5'd0; req0_data = 32'h0; req1_data = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rw", {31'd0, RegWrite}, 32'd0);
      chk("rst_wreg", {27'd0, WriteReg}, 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_done", {31'd0, init_done}, 32'd0);
      chk("rst_cnt", {29'd0, conflict_cnt}, 32'd0);
      chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1; req0_valid = 1'b0;

      // Initial sweep: 32 writes of INIT_D
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         chk("sweep_rw", {31'd0, RegWrite}, 32'd1);
         chk("sweep_wreg", {27'd0, WriteReg}, i);
         chk("sweep_wdata", WriteData, INIT_D);
         if (i < 31) chk("sweep_done", {31'd0, init_done}, 32'd0);
      end

      // Table-driven RUN vectors
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         req0_valid = vecs[k].v0; req0_reg = vecs[k].r0; req0_data = vecs[k].d0;
         req1_valid = vecs[k].v1; req1_reg = vecs[k].r1; req1_data = vecs[k].d1;
         #1;
         chk($sformatf("v%0d_rdy0", k), {31'd0, req0_ready}, {31'd0, vecs[k].rdy0});
         chk($sformatf("v%0d_rdy1", k), {31'd0, req1_ready}, {31'd0, vecs[k].rdy1});
         @(posedge clk); #1;
         chk($sformatf("v%0d_rw", k), {31'd0, RegWrite}, {31'd0, vecs[k].rw});
         chk($sformatf("v%0d_wreg", k), {27'd0, WriteReg}, {27'd0, vecs[k].wreg});
         chk($sformatf("v%0d_wdata", k), WriteData, vecs[k].wdata);
         chk($sformatf("v%0d_cnt", k), {29'd0, conflict_cnt}, {29'd0, vecs[k].cnt});
         chk($sformatf("v%0d_done", k), {31'd0, init_done}, 32'd1);
      end

      // init_req while req0 valid: refused, sweep repeats, then accepted
      @(negedge clk);
      req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 32'hCCCC_0012;
      req1_valid = 1'b0; init_req = 1'b1;
      #1;
      chk("ireq_rdy0", {31'd0, req0_ready}, 32'd0);
      @(posedge clk); #1;
      chk("ireq_done", {31'd0, init_done}, 32'd0);
      chk("ireq_rw", {31'd0, RegWrite}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         init_req = 1'b0;
         #1;
         chk("resweep_rdy0", {31'd0, req0_ready}, 32'd0);
         @(posedge clk); #1;
         chk("resweep_rw", {31'd0, RegWrite}, 32'd1);
         chk("resweep_wreg", {27'd0, WriteReg}, i);
      end
      @(negedge clk); #1;
      chk("post_rdy0", {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      chk("post_rw", {31'd0, RegWrite}, 32'd1);
      chk("post_wreg", {27'd0, WriteReg}, 32'd12);
      chk("post_wdata", WriteData, 32'hCCCC_0012);
      chk("post_done", {31'd0, init_done}, 32'd1);

      // Contention counter saturates at all-ones
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req0_valid = 1'b1; req0_reg = 5'd13; req0_data = k;
         req1_valid = 1'b1; req1_reg = 5'd14; req1_data = k;
         @(posedge clk); #1;
         chk("sat_cnt", {29'd0, conflict_cnt}, (6 + k > 7) ? 32'd7 : 6 + k);
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Reset in the middle of a sweep
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("mid_wreg", {27'd0, WriteReg}, 32'd16);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("arst_rw", {31'd0, RegWrite}, 32'd0);
      chk("arst_wreg", {27'd0, WriteReg}, 32'd0);
      chk("arst_wdata", WriteData, 32'd0);
      chk("arst_done", {31'd0, init_done}, 32'd0);
      chk("arst_cnt", {29'd0, conflict_cnt}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("restart_rw", {31'd0, RegWrite}, 32'd1);
      chk("restart_wreg", {27'd0, WriteReg}, 32'd0);
      chk("restart_wdata", WriteData, INIT_D);
      @(posedge clk); #1;
      chk("restart_wreg1", {27'd0, WriteReg}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
